// File: rtl/fp_sqrt_issue_pkg.sv
// Shared types, constants and helpers for the fp_sqrt issue stage.
// - DATA_WIDTH        : IEEE-754 single-precision operand/result width
// - fp_issue_state_t  : issue FSM state encoding
// - FP32_QNAN/POS_INF : canonical special results
// - fp32_is_special() : true when sqrt(x) is fixed without iteration
// - fp32_special_result() : the fixed result for such operands
package fp_sqrt_issue_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] FP32_POS_INF = 32'h7F80_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } fp_issue_state_t;

  // Zero of either sign, anything negative, Inf or NaN. Positive
  // denormals are not special: they still need the iterative unit.
  function automatic logic fp32_is_special(input logic [31:0] x);
    logic is_zero;
    logic exp_ones;
    is_zero  = (x[30:0] == 31'd0);
    exp_ones = &x[30:23];
    return is_zero || x[31] || exp_ones;
  endfunction

  // sqrt(+-0) keeps its sign, sqrt(+Inf) = +Inf, everything else that is
  // special (NaN, -Inf, negative non-zero) becomes the canonical quiet NaN.
  function automatic logic [31:0] fp32_special_result(input logic [31:0] x);
    if (x[30:0] == 31'd0) begin
      return x;
    end
    if (!x[31] && (&x[30:23]) && (x[22:0] == 23'd0)) begin
      return FP32_POS_INF;
    end
    return FP32_QNAN;
  endfunction

endpackage

// File: rtl/fp_sqrt_issue_if.sv
// Request/response bus between FPU dispatch and the sqrt issue stage.
// - req_valid/req_ready/req_operand/req_tag : tagged request, valid/ready
// - rsp_valid/rsp_ready/rsp_data/rsp_tag    : tagged result, valid/ready
// master = dispatch side, slave = issue stage.
interface fp_sqrt_issue_if #(
  parameter int TAG_W = 8
);
  import fp_sqrt_issue_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic [DATA_WIDTH-1:0] req_operand;
  logic [TAG_W-1:0]      req_tag;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [TAG_W-1:0]      rsp_tag;

  modport master (
    output req_valid, req_operand, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_tag
  );

  modport slave (
    input  req_valid, req_operand, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_tag
  );

endinterface

// File: rtl/fp_sqrt_issue_fifo.sv
// In-order request FIFO for the sqrt issue stage.
// - clk, rst      : clock, synchronous active-high reset
// - flush         : empty the FIFO this cycle
// - push/push_data: write one entry (caller guarantees not full)
// - pop           : remove the head (caller guarantees not empty)
// - pop_data      : registered copy of the entry removed by the last pop
// - occupancy     : entry count, full/empty decoded from it
module fp_issue_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [OCC_W-1:0] count_reg;
  logic [WIDTH-1:0] pop_data_reg;

  // Storage has no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers are power-of-two sized and wrap on their own.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Registered read: the popped entry is available the cycle after pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      pop_data_reg <= '0;
    end else if (pop) begin
      pop_data_reg <= mem[rd_ptr_reg];
    end
  end

  assign pop_data  = pop_data_reg;
  assign occupancy = count_reg;
  assign full      = (count_reg == OCC_W'(DEPTH));
  assign empty     = (count_reg == '0);

endmodule

// File: rtl/fp_sqrt_issue.sv
// Issue stage in front of the multi-cycle, non-stallable fp_sqrt unit.
// Buffers tagged requests, launches one operation at a time with a
// single-cycle sqrt_start, and returns results through a backpressured
// response register. A launch only happens when that register is free,
// so an fp_sqrt result always has somewhere to go.
// Ports:
// - clk, rst      : clock, synchronous active-high reset
// - bus (slave)   : request and response handshakes, see fp_sqrt_issue_if
// - sqrt_start    : one-cycle launch pulse to fp_sqrt
// - sqrt_operand  : operand, stable from launch until sqrt_valid
// - sqrt_result/sqrt_valid/sqrt_busy : fp_sqrt result, strobe, busy
// - flush         : drop queued work, the held response and any in-flight op
// - occupancy     : request FIFO entry count
// Build option: OPENGPU_SQRT_FASTPATH_EN answers zero/negative/Inf/NaN
// operands locally instead of sending them to fp_sqrt.
module fp_sqrt_issue
  import fp_sqrt_issue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  fp_sqrt_issue_if.slave         bus,
  output logic                   sqrt_start,
  output logic [DATA_WIDTH-1:0]  sqrt_operand,
  input  logic [DATA_WIDTH-1:0]  sqrt_result,
  input  logic                   sqrt_valid,
  input  logic                   sqrt_busy,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int ENTRY_W = DATA_WIDTH + TAG_W;

  fp_issue_state_t state_reg, state_next;
  logic                  drop_reg, drop_next;
  logic [DATA_WIDTH-1:0] inflight_operand_reg, inflight_operand_next;
  logic [TAG_W-1:0]      inflight_tag_reg, inflight_tag_next;
  logic                  rsp_valid_reg, rsp_valid_next;
  logic [DATA_WIDTH-1:0] rsp_data_reg, rsp_data_next;
  logic [TAG_W-1:0]      rsp_tag_reg, rsp_tag_next;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [ENTRY_W-1:0]    fifo_head;
  logic [DATA_WIDTH-1:0] head_operand;
  logic [TAG_W-1:0]      head_tag;

  logic                  rsp_free;
  logic                  rsp_load;
  logic [DATA_WIDTH-1:0] load_data;
  logic [TAG_W-1:0]      load_tag;
  logic                  fast_hit;
  logic [DATA_WIDTH-1:0] fast_result;

  assign bus.req_ready = !fifo_full && !flush;
  assign fifo_push     = bus.req_valid && bus.req_ready;

  fp_issue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (fifo_push),
    .push_data ({bus.req_operand, bus.req_tag}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .occupancy (occupancy),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign {head_operand, head_tag} = fifo_head;

`ifdef OPENGPU_SQRT_FASTPATH_EN
  assign fast_hit    = fp32_is_special(head_operand);
  assign fast_result = fp32_special_result(head_operand);
`else
  assign fast_hit    = 1'b0;
  assign fast_result = '0;
`endif

  // Free after this cycle's handshake, so a launch can overlap the
  // consumption of the previous response.
  assign rsp_free = !rsp_valid_reg || bus.rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg            <= IDLE;
      drop_reg             <= 1'b0;
      inflight_operand_reg <= '0;
      inflight_tag_reg     <= '0;
      rsp_valid_reg        <= 1'b0;
      rsp_data_reg         <= '0;
      rsp_tag_reg          <= '0;
    end else begin
      state_reg            <= state_next;
      drop_reg             <= drop_next;
      inflight_operand_reg <= inflight_operand_next;
      inflight_tag_reg     <= inflight_tag_next;
      rsp_valid_reg        <= rsp_valid_next;
      rsp_data_reg         <= rsp_data_next;
      rsp_tag_reg          <= rsp_tag_next;
    end
  end

  always_comb begin
    state_next            = state_reg;
    drop_next             = drop_reg;
    inflight_operand_next = inflight_operand_reg;
    inflight_tag_next     = inflight_tag_reg;
    fifo_pop              = 1'b0;
    sqrt_start            = 1'b0;
    rsp_load              = 1'b0;
    load_data             = sqrt_result;
    load_tag              = inflight_tag_reg;

    case (state_reg)
      IDLE: begin
        // The head is popped on the way into LAUNCH so the registered
        // FIFO read delivers it during LAUNCH.
        if (!fifo_empty && rsp_free && !sqrt_busy && !flush) begin
          fifo_pop   = 1'b1;
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        if (flush) begin
          // The popped head belongs to the discarded queue.
          state_next = IDLE;
        end else if (fast_hit) begin
          rsp_load   = 1'b1;
          load_data  = fast_result;
          load_tag   = head_tag;
          state_next = IDLE;
        end else begin
          sqrt_start            = 1'b1;
          inflight_operand_next = head_operand;
          inflight_tag_next     = head_tag;
          state_next            = WAIT;
        end
      end
      WAIT: begin
        if (sqrt_valid) begin
          // A flush arriving with the result discards it as well.
          rsp_load   = !drop_reg && !flush;
          drop_next  = 1'b0;
          state_next = IDLE;
        end else if (flush) begin
          drop_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    rsp_valid_next = rsp_valid_reg;
    rsp_data_next  = rsp_data_reg;
    rsp_tag_next   = rsp_tag_reg;
    if (rsp_valid_reg && bus.rsp_ready) begin
      rsp_valid_next = 1'b0;
    end
    if (rsp_load) begin
      rsp_valid_next = 1'b1;
      rsp_data_next  = load_data;
      rsp_tag_next   = load_tag;
    end
    if (flush) begin
      rsp_valid_next = 1'b0;
    end
  end

  // During LAUNCH the operand comes straight from the FIFO read register;
  // afterwards the latched copy keeps it stable until the result returns.
  assign sqrt_operand = (state_reg == LAUNCH) ? head_operand : inflight_operand_reg;

  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.rsp_tag   = rsp_tag_reg;

endmodule

// File: tb/tb_fp_sqrt_issue.sv
`timescale 1ns/1ps
module tb_fp_sqrt_issue;

  localparam int DEPTH = 4;
  localparam int TAG_W = 8;
  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             sqrt_start;
  logic [31:0]      sqrt_operand;
  logic [31:0]      sqrt_result;
  logic             sqrt_valid;
  logic             sqrt_busy;
  logic [OCC_W-1:0] occupancy;

  int errors = 0;
  int checks = 0;

  fp_sqrt_issue_if #(.TAG_W(TAG_W)) bus ();

  fp_sqrt_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .sqrt_start   (sqrt_start),
    .sqrt_operand (sqrt_operand),
    .sqrt_result  (sqrt_result),
    .sqrt_valid   (sqrt_valid),
    .sqrt_busy    (sqrt_busy),
    .flush        (flush),
    .occupancy    (occupancy)
  );

  always #5 clk = ~clk;

  // ---------------- arithmetic reference helpers ----------------
  function automatic logic [31:0] int_to_fp32(input int unsigned v);
    int msb;
    logic [31:0] m;
    msb = 0;
    if (v == 0) return 32'h0;
    for (int i = 0; i < 32; i++) if (v[i]) msb = i;
    m = v << (23 - msb);
    return {1'b0, 8'(127 + msb), m[22:0]};
  endfunction

  function automatic int unsigned fp32_to_int(input logic [31:0] x);
    int e;
    int unsigned m;
    e = int'(x[30:23]) - 127;
    m = {8'd0, 1'b1, x[22:0]};
    return m >> (23 - e);
  endfunction

  function automatic int unsigned isqrt(input int unsigned v);
    longint r;
    r = 0;
    while ((r + 1) * (r + 1) <= longint'(v)) r++;
    return int'(r);
  endfunction

  // Behavioural fp_sqrt for integer-valued operands plus special cases.
  function automatic logic [31:0] stub_sqrt(input logic [31:0] x);
    if (x[30:0] == 31'd0) return x;
    if (x[31] || ((&x[30:23]) && x[22:0] != 0)) return QNAN;
    if (&x[30:23]) return 32'h7F80_0000;
    return int_to_fp32(isqrt(fp32_to_int(x)));
  endfunction

  // ---------------- fp_sqrt stand-in ----------------
  logic        stub_valid;
  logic        inject_valid = 1'b0;
  logic [31:0] stub_op;
  int          stub_cnt;
  int          start_count = 0;

  assign sqrt_valid = stub_valid | inject_valid;

  always @(posedge clk) begin
    if (rst) begin
      stub_valid  <= 1'b0;
      sqrt_busy   <= 1'b0;
      stub_cnt    <= 0;
      sqrt_result <= 32'h0;
      stub_op     <= 32'h0;
    end else begin
      stub_valid <= 1'b0;
      if (sqrt_start) begin
        start_count <= start_count + 1;
        stub_op     <= sqrt_operand;
        sqrt_busy   <= 1'b1;
        // normal operands: valid 7 cycles after start; specials: 3
        stub_cnt    <= (sqrt_operand[31] || (&sqrt_operand[30:23]) ||
                        sqrt_operand[30:0] == 31'd0) ? 2 : 6;
      end else if (stub_cnt > 0) begin
        stub_cnt <= stub_cnt - 1;
        if (stub_cnt == 1) begin
          stub_valid  <= 1'b1;
          sqrt_busy   <= 1'b0;
          sqrt_result <= stub_sqrt(stub_op);
        end
      end
    end
  end

  // ---------------- checking ----------------
  logic [39:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every accepted response must match the oldest expected one, in order.
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      check("rsp_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        logic [39:0] e;
        e = exp_q.pop_front();
        check("rsp_data", 64'(bus.rsp_data), 64'(e[31:0]));
        check("rsp_tag", 64'(bus.rsp_tag), 64'(e[39:32]));
        $display("rsp tag=%02h data=%08h expected=%08h", bus.rsp_tag, bus.rsp_data, e[31:0]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_req(input logic [31:0] op, input logic [7:0] tag,
                          input logic [31:0] exp, input bit track);
    int n;
    n = 0;
    while (!bus.req_ready && n < 200) begin
      step();
      n++;
    end
    check("push_ready", 64'(bus.req_ready), 64'(1));
    bus.req_valid   = 1'b1;
    bus.req_operand = op;
    bus.req_tag     = tag;
    if (track) exp_q.push_back({tag, exp});
    $display("req tag=%02h operand=%08h expect=%08h", tag, op, exp);
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 600) begin
      step();
      n++;
    end
    check(tag, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_ready"}, 64'(bus.req_ready), 64'(1));
    check({tag, "_sqrt_start"}, 64'(sqrt_start), 64'(0));
    check({tag, "_sqrt_operand"}, 64'(sqrt_operand), 64'(0));
    check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
    check({tag, "_rsp_data"}, 64'(bus.rsp_data), 64'(0));
    check({tag, "_rsp_tag"}, 64'(bus.rsp_tag), 64'(0));
    check({tag, "_occupancy"}, 64'(occupancy), 64'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int n;
    bus.req_valid   = 1'b0;
    bus.req_operand = 32'h0;
    bus.req_tag     = 8'h0;
    bus.rsp_ready   = 1'b0;

    // ---- reset state ----
    rst = 1'b1;
    repeat (3) step();
    check_reset_values("reset");
    rst = 1'b0;
    step();

    // ---- single request, launch timing and latency ----
    bus.rsp_ready = 1'b1;
    s0 = start_count;
    push_req(32'h4080_0000, 8'h11, 32'h4000_0000, 1'b1);
    check("t1_occ_after_push", 64'(occupancy), 64'(1));
    check("t1_no_start_yet", 64'(sqrt_start), 64'(0));
    step();
    check("t1_start", 64'(sqrt_start), 64'(1));
    check("t1_operand", 64'(sqrt_operand), 64'(32'h4080_0000));
    check("t1_occ_after_pop", 64'(occupancy), 64'(0));
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      step();
      n++;
    end
    check("t1_rsp_latency", 64'(n), 64'(8));
    drain("t1_drain");
    check("t1_start_count", 64'(start_count - s0), 64'(1));

    // ---- backpressure: four requests, rsp_ready low ----
    bus.rsp_ready = 1'b0;
    s0 = start_count;
    for (int i = 0; i < 4; i++) begin
      push_req(int_to_fp32((i + 1) * (i + 1)), 8'(i), int_to_fp32(i + 1), 1'b1);
    end
    check("t2_occ_after_launch", 64'(occupancy), 64'(3));
    repeat (40) step();
    check("t2_single_start", 64'(start_count - s0), 64'(1));
    check("t2_rsp_held", 64'(bus.rsp_valid), 64'(1));
    check("t2_rsp_held_data", 64'(bus.rsp_data), 64'(32'h3F80_0000));
    check("t2_occ_held", 64'(occupancy), 64'(3));
    // push and pop in the same cycle at DEPTH-1
    bus.req_valid   = 1'b1;
    bus.req_operand = int_to_fp32(25);
    bus.req_tag     = 8'h04;
    exp_q.push_back({8'h04, int_to_fp32(5)});
    bus.rsp_ready   = 1'b1;
    step();
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    check("t2_occ_push_pop", 64'(occupancy), 64'(3));
    check("t2_ready_push_pop", 64'(bus.req_ready), 64'(1));
    check("t2_relaunch", 64'(sqrt_start), 64'(1));
    push_req(int_to_fp32(36), 8'h05, int_to_fp32(6), 1'b1);
    check("t2_occ_full", 64'(occupancy), 64'(4));
    check("t2_ready_full", 64'(bus.req_ready), 64'(0));
    bus.rsp_ready = 1'b1;
    drain("t2_drain");
    check("t2_start_total", 64'(start_count - s0), 64'(6));

    // ---- negative operand ----
    s0 = start_count;
    push_req(32'hBF80_0000, 8'h22, QNAN, 1'b1);
`ifdef OPENGPU_SQRT_FASTPATH_EN
    step();
    check("t3_no_start", 64'(sqrt_start), 64'(0));
    step();
    check("t3_fast_rsp", 64'(bus.rsp_valid), 64'(1));
    drain("t3_drain");
    check("t3_start_count", 64'(start_count - s0), 64'(0));
`else
    drain("t3_drain");
    check("t3_start_count", 64'(start_count - s0), 64'(1));
`endif

    // ---- flush during WAIT with two entries queued ----
    s0 = start_count;
    push_req(int_to_fp32(25), 8'h31, 32'h0, 1'b0);
    push_req(int_to_fp32(36), 8'h32, 32'h0, 1'b0);
    push_req(int_to_fp32(49), 8'h33, 32'h0, 1'b0);
    step();
    step();
    check("t4_occ_before_flush", 64'(occupancy), 64'(2));
    flush = 1'b1;
    #1;
    check("t4_ready_during_flush", 64'(bus.req_ready), 64'(0));
    step();
    flush = 1'b0;
    check("t4_occ_after_flush", 64'(occupancy), 64'(0));
    repeat (12) step();
    check("t4_no_relaunch", 64'(start_count - s0), 64'(1));
    check("t4_dropped", 64'(bus.rsp_valid), 64'(0));
    push_req(32'h4180_0000, 8'h44, 32'h4080_0000, 1'b1);
    drain("t4_drain");
    check("t4_start_total", 64'(start_count - s0), 64'(2));

    // ---- random perfect squares and negatives, 3*DEPTH requests ----
    for (int i = 0; i < 3 * DEPTH; i++) begin
      int unsigned k;
      bit neg;
      logic [31:0] op;
      k   = $urandom_range(1, 4095);
      neg = ($urandom_range(0, 3) == 0);
      op  = int_to_fp32(k * k);
      op[31] = neg;
      push_req(op, 8'($urandom), neg ? QNAN : int_to_fp32(k), 1'b1);
    end
    drain("t5_drain");

    // ---- reset while an operation is in flight ----
    push_req(int_to_fp32(25), 8'h51, 32'h0, 1'b0);
    push_req(int_to_fp32(36), 8'h52, 32'h0, 1'b0);
    push_req(int_to_fp32(49), 8'h53, 32'h0, 1'b0);
    step();
    rst = 1'b1;
    step();
    check_reset_values("t6");
    rst = 1'b0;
    s0 = start_count;
    inject_valid = 1'b1;
    step();
    inject_valid = 1'b0;
    repeat (3) step();
    check("t6_stray_ignored", 64'(bus.rsp_valid), 64'(0));
    check("t6_no_start", 64'(start_count - s0), 64'(0));
    push_req(int_to_fp32(9), 8'h66, int_to_fp32(3), 1'b1);
    drain("t6_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
